// File: rtl/stage_memory.sv
// -----------------------------------------------------------------------------
// stage_memory
//   Pipeline stage 4 (MEM). Registers the MEM/WB results and turns
//   execute-stage loads and stores into a req/ack data-memory transaction
//   with variable latency. Builds byte lanes for stores, sign/zero extends
//   loads, stalls upstream while a transaction is outstanding, and reports
//   misaligned accesses and memory timeouts.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | accept an instruction; non-mem and misaligned ops retire here
//   REQ   | dmem_req high, waiting for dmem_ack or the timeout limit
//   RESP  | out_valid pulse with the memory result, upstream released
//
// Ports
//   clk, reset               clock (rising edge), synchronous active-high reset
//   in_*                     execute-stage results and control
//   out_stall                upstream must hold (combinational)
//   out_*                    registered MEM/WB results, out_valid is a pulse
//   dmem_*                   data-memory req/ack interface
// -----------------------------------------------------------------------------
module stage_memory #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_mem_to_reg,
  input  logic        in_write_enable,
  output logic        out_stall,
  output logic        out_valid,
  output logic [31:0] out_alu_out,
  output logic [31:0] out_mem_data,
  output logic [4:0]  out_rd,
  output logic        out_mem_to_reg,
  output logic        out_write_enable,
  output logic        out_misaligned,
  output logic        out_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;

  logic        r_out_valid;
  logic [31:0] r_out_alu_out;
  logic [31:0] r_out_mem_data;
  logic [4:0]  r_out_rd;
  logic        r_out_mem_to_reg;
  logic        r_out_write_enable;
  logic        r_out_misaligned;
  logic        r_out_fault;

  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_wstrb;

  // Per-transaction context kept while the access is outstanding
  logic        r_is_load;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic        r_we_pend;

  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_accept_mem;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_is_mem = in_mem_read | in_mem_write;

  // Size from funct3[1:0]: 00 byte, 01 half, anything else is a word access
  always_comb begin
    w_misaligned = 1'b0;
    if (in_funct3[1:0] == 2'b01)
      w_misaligned = in_alu_out[0];
    else if (in_funct3[1])
      w_misaligned = (in_alu_out[1:0] != 2'b00);
  end

  assign w_accept_mem = (r_state == ST_IDLE) && in_valid && w_is_mem && !w_misaligned;
  assign out_stall    = w_accept_mem || (r_state == ST_REQ);

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = in_rs2;
    case (in_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << in_alu_out[1:0];
        w_wdata = {4{in_rs2[7:0]}};
      end
      2'b01: begin
        w_wstrb = in_alu_out[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{in_rs2[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = in_rs2;
      end
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_addr_lo)
      2'd0: w_byte = dmem_rdata[7:0];
      2'd1: w_byte = dmem_rdata[15:8];
      2'd2: w_byte = dmem_rdata[23:16];
      2'd3: w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
  end

  assign w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_load_data = dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= ST_IDLE;
      r_cnt              <= '0;
      r_out_valid        <= 1'b0;
      r_out_alu_out      <= 32'd0;
      r_out_mem_data     <= 32'd0;
      r_out_rd           <= 5'd0;
      r_out_mem_to_reg   <= 1'b0;
      r_out_write_enable <= 1'b0;
      r_out_misaligned   <= 1'b0;
      r_out_fault        <= 1'b0;
      r_dmem_we          <= 1'b0;
      r_dmem_addr        <= 32'd0;
      r_dmem_wdata       <= 32'd0;
      r_dmem_wstrb       <= 4'd0;
      r_is_load          <= 1'b0;
      r_addr_lo          <= 2'd0;
      r_funct3           <= 3'd0;
      r_we_pend          <= 1'b0;
    end else begin
      r_out_valid      <= 1'b0;
      r_out_misaligned <= 1'b0;
      r_out_fault      <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_out_alu_out    <= in_alu_out;
            r_out_rd         <= in_rd;
            r_out_mem_to_reg <= in_mem_to_reg;
            if (!w_is_mem || w_misaligned) begin
              // Retires in one cycle; a misaligned access is never issued
              r_out_valid        <= 1'b1;
              r_out_mem_data     <= 32'd0;
              r_out_write_enable <= w_is_mem ? 1'b0 : in_write_enable;
              r_out_misaligned   <= w_is_mem;
            end else begin
              r_dmem_we    <= in_mem_write;
              r_dmem_addr  <= {in_alu_out[31:2], 2'b00};
              r_dmem_wdata <= in_mem_write ? w_wdata : 32'd0;
              r_dmem_wstrb <= in_mem_write ? w_wstrb : 4'd0;
              // A store wins when both read and write are flagged
              r_is_load    <= ~in_mem_write;
              r_addr_lo    <= in_alu_out[1:0];
              r_funct3     <= in_funct3;
              r_we_pend    <= in_write_enable;
              r_cnt        <= '0;
              r_state      <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (dmem_ack) begin
            r_out_valid        <= 1'b1;
            r_out_mem_data     <= r_is_load ? w_load_data : 32'd0;
            r_out_write_enable <= r_we_pend;
            r_state            <= ST_RESP;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_out_valid        <= 1'b1;
            r_out_fault        <= 1'b1;
            r_out_mem_data     <= 32'd0;
            r_out_write_enable <= 1'b0;
            r_state            <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dmem_req         = (r_state == ST_REQ);
  assign dmem_we          = r_dmem_we;
  assign dmem_addr        = r_dmem_addr;
  assign dmem_wdata       = r_dmem_wdata;
  assign dmem_wstrb       = r_dmem_wstrb;

  assign out_valid        = r_out_valid;
  assign out_alu_out      = r_out_alu_out;
  assign out_mem_data     = r_out_mem_data;
  assign out_rd           = r_out_rd;
  assign out_mem_to_reg   = r_out_mem_to_reg;
  assign out_write_enable = r_out_write_enable;
  assign out_misaligned   = r_out_misaligned;
  assign out_fault        = r_out_fault;

endmodule

// File: tb/tb_stage_memory.sv
// -----------------------------------------------------------------------------
// tb_stage_memory
//   Directed bench for stage_memory. Each task drives one scenario and
//   compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_stage_memory;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu_out;
  logic [31:0] in_rs2;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_mem_to_reg;
  logic        in_write_enable;
  logic        out_stall;
  logic        out_valid;
  logic [31:0] out_alu_out;
  logic [31:0] out_mem_data;
  logic [4:0]  out_rd;
  logic        out_mem_to_reg;
  logic        out_write_enable;
  logic        out_misaligned;
  logic        out_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int errors = 0;
  int checks = 0;

  stage_memory #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_alu_out(in_alu_out), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .in_write_enable(in_write_enable),
    .out_stall(out_stall), .out_valid(out_valid), .out_alu_out(out_alu_out),
    .out_mem_data(out_mem_data), .out_rd(out_rd), .out_mem_to_reg(out_mem_to_reg),
    .out_write_enable(out_write_enable), .out_misaligned(out_misaligned),
    .out_fault(out_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_alu_out = 0; in_rs2 = 0; in_funct3 = 0; in_rd = 0;
    in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0; in_write_enable = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", out_stall); end
    checks++; if (out_alu_out !== 32'd0 || out_mem_data !== 32'd0 || dmem_wstrb !== 4'd0)
      begin errors++; $display("FAIL reset_data: alu %h mem %h wstrb %b expected zeros", out_alu_out, out_mem_data, dmem_wstrb); end
    reset = 0;
    tick();
  endtask

  task automatic test_alu_op();
    in_valid = 1; in_alu_out = 32'h1234; in_rd = 5; in_write_enable = 1;
    #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", out_stall); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b expected 1", out_valid); end
    checks++; if (out_alu_out !== 32'h1234 || out_rd !== 5'd5)
      begin errors++; $display("FAIL alu_result: alu %h rd %0d expected 1234 rd 5", out_alu_out, out_rd); end
    checks++; if (out_write_enable !== 1'b1 || out_mem_data !== 32'd0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL alu_ctrl: we %b mem %h req %b expected 1 0 0", out_write_enable, out_mem_data, dmem_req); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse: got %b expected 0", out_valid); end
    // Ack while idle must be ignored
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 0;
    checks++; if (out_valid !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL stray_ack: valid %b req %b expected 0 0", out_valid, dmem_req); end
  endtask

  task automatic test_load_byte();
    idle_inputs();
    in_valid = 1; in_alu_out = 32'h103; in_funct3 = 3'b000; in_rd = 7;
    in_mem_read = 1; in_mem_to_reg = 1; in_write_enable = 1;
    #1;
    checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL lb_accept_stall: got %b expected 1", out_stall); end
    tick();
    checks++; if (dmem_addr !== 32'h100 || dmem_we !== 1'b0 || dmem_wstrb !== 4'd0)
      begin errors++; $display("FAIL lb_req: addr %h we %b wstrb %b expected 100 0 0000", dmem_addr, dmem_we, dmem_wstrb); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (dmem_req !== 1'b1 || out_stall !== 1'b1 || out_valid !== 1'b0)
        begin errors++; $display("FAIL lb_wait%0d: req %b stall %b valid %b expected 1 1 0", i, dmem_req, out_stall, out_valid); end
      tick();
    end
    dmem_ack = 1; dmem_rdata = 32'h80FF_FF7F;
    tick();
    dmem_ack = 0;
    checks++; if (out_valid !== 1'b1 || out_stall !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL lb_resp: valid %b stall %b req %b expected 1 0 0", out_valid, out_stall, dmem_req); end
    checks++; if (out_mem_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", out_mem_data); end
    checks++; if (out_rd !== 5'd7 || out_write_enable !== 1'b1 || out_mem_to_reg !== 1'b1 || out_alu_out !== 32'h103)
      begin errors++; $display("FAIL lb_ctrl: rd %0d we %b m2r %b alu %h expected 7 1 1 103", out_rd, out_write_enable, out_mem_to_reg, out_alu_out); end
    in_valid = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lb_pulse: got %b expected 0", out_valid); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [4] = '{3'b001, 3'b101, 3'b100, 3'b010};
    logic [31:0] adr [4] = '{32'h606, 32'h606, 32'h601, 32'h608};
    logic [31:0] rd  [4] = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h1234_F056, 32'hCAFE_F00D};
    logic [31:0] exp [4] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_00F0, 32'hCAFE_F00D};
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      in_valid = 1; in_alu_out = adr[i]; in_funct3 = f3[i]; in_rd = 9;
      in_mem_read = 1; in_mem_to_reg = 1; in_write_enable = 1;
      tick();
      dmem_ack = 1; dmem_rdata = rd[i];
      tick();
      dmem_ack = 0; in_valid = 0;
      checks++; if (out_valid !== 1'b1 || out_mem_data !== exp[i])
        begin errors++; $display("FAIL load_ext%0d: valid %b data %h expected 1 %h", i, out_valid, out_mem_data, exp[i]); end
      tick();
    end
  endtask

  task automatic test_store();
    idle_inputs();
    in_valid = 1; in_alu_out = 32'h202; in_rs2 = 32'hABCD_1234; in_funct3 = 3'b001;
    in_mem_write = 1; in_rd = 0;
    tick();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200)
      begin errors++; $display("FAIL sh_req: req %b we %b addr %h expected 1 1 200", dmem_req, dmem_we, dmem_addr); end
    checks++; if (dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'h1234_1234)
      begin errors++; $display("FAIL sh_lanes: wstrb %b wdata %h expected 1100 12341234", dmem_wstrb, dmem_wdata); end
    dmem_ack = 1;
    tick();
    dmem_ack = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_write_enable !== 1'b0 || out_mem_data !== 32'd0)
      begin errors++; $display("FAIL sh_resp: valid %b we %b data %h expected 1 0 0", out_valid, out_write_enable, out_mem_data); end
    tick();
    // SB with read and write both set: must be issued as a store
    in_valid = 1; in_alu_out = 32'h301; in_rs2 = 32'h1122_335A; in_funct3 = 3'b000;
    in_mem_write = 1; in_mem_read = 1;
    tick();
    checks++; if (dmem_we !== 1'b1 || dmem_wstrb !== 4'b0010 || dmem_wdata !== 32'h5A5A_5A5A || dmem_addr !== 32'h300)
      begin errors++; $display("FAIL sb_lanes: we %b wstrb %b wdata %h addr %h expected 1 0010 5a5a5a5a 300", dmem_we, dmem_wstrb, dmem_wdata, dmem_addr); end
    dmem_ack = 1;
    tick();
    dmem_ack = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_mem_data !== 32'd0)
      begin errors++; $display("FAIL sb_resp: valid %b data %h expected 1 0", out_valid, out_mem_data); end
    tick();
  endtask

  task automatic test_misaligned();
    idle_inputs();
    in_valid = 1; in_alu_out = 32'h101; in_funct3 = 3'b010; in_rd = 4;
    in_mem_read = 1; in_mem_to_reg = 1; in_write_enable = 1;
    #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b expected 0", out_stall); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_misaligned !== 1'b1 || out_write_enable !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL mis_resp: valid %b mis %b we %b req %b expected 1 1 0 0", out_valid, out_misaligned, out_write_enable, dmem_req); end
    tick();
    checks++; if (out_misaligned !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL mis_pulse: mis %b req %b expected 0 0", out_misaligned, dmem_req); end
    // Halfword at odd address is also misaligned
    in_valid = 1; in_alu_out = 32'h203; in_funct3 = 3'b001; in_mem_read = 0; in_mem_write = 1;
    tick();
    in_valid = 0;
    checks++; if (out_misaligned !== 1'b1 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL mis_half: mis %b req %b expected 1 0", out_misaligned, dmem_req); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    idle_inputs();
    in_valid = 1; in_alu_out = 32'h400; in_funct3 = 3'b010; in_rd = 6;
    in_mem_read = 1; in_mem_to_reg = 1; in_write_enable = 1;
    tick();
    n = 0;
    while (dmem_req === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL to_cycles: req high %0d cycles expected 64", n); end
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_write_enable !== 1'b0 || out_mem_data !== 32'd0)
      begin errors++; $display("FAIL to_resp: valid %b fault %b we %b data %h expected 1 1 0 0", out_valid, out_fault, out_write_enable, out_mem_data); end
    in_valid = 0;
    tick();
    in_valid = 1; in_alu_out = 32'h55; in_rd = 3; in_mem_read = 0; in_mem_to_reg = 0;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b0 || out_alu_out !== 32'h55 || out_write_enable !== 1'b1)
      begin errors++; $display("FAIL to_resume: valid %b fault %b alu %h we %b expected 1 0 55 1", out_valid, out_fault, out_alu_out, out_write_enable); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    in_valid = 1; in_alu_out = 32'h500; in_funct3 = 3'b010; in_mem_read = 1; in_write_enable = 1;
    tick();
    tick();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rm_inreq: got %b expected 1", dmem_req); end
    reset = 1; in_valid = 0;
    tick();
    reset = 0;
    checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rm_abort: req %b valid %b expected 0 0", dmem_req, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_novalid: got %b expected 0", out_valid); end
    in_valid = 1; in_alu_out = 32'h502; in_funct3 = 3'b100; in_rd = 12; in_mem_to_reg = 1;
    tick();
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h500)
      begin errors++; $display("FAIL rm_lbu_req: req %b addr %h expected 1 500", dmem_req, dmem_addr); end
    dmem_ack = 1; dmem_rdata = 32'h00C3_0000;
    tick();
    dmem_ack = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_mem_data !== 32'h0000_00C3 || out_rd !== 5'd12)
      begin errors++; $display("FAIL rm_lbu: valid %b data %h rd %0d expected 1 c3 12", out_valid, out_mem_data, out_rd); end
    tick();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_alu_op();
    test_load_byte();
    test_load_ext();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
